// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: program load port, execute-core redirect path and
// the instruction/commit outputs presented to the execute core.
interface instr_fetch_if #(
    parameter int AW = 6
);
    logic          start;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   instruction;
    logic          write_enable;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          error;

    modport master (
        output start, prog_we, prog_addr, prog_data, redirect, redirect_pc,
        input  instruction, write_enable, pc, busy, done, error
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_data, redirect, redirect_pc,
        output instruction, write_enable, pc, busy, done, error
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: FETCH/SETUP/COMMIT sequencer over a private instruction RAM.
// Optional macro IFETCH_JUMP_DECODE_EN enables local decode of J/JAL targets.
module instr_fetch #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic         clock,
    input  logic         reset,
    instr_fetch_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_COMMIT,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

    state_t        state_reg;
    logic [AW-1:0] pc_reg;
    logic [31:0]   instruction_reg;
    logic          write_enable_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          error_reg;

    logic [31:0]   mem [DEPTH];

    logic          redirect_in_range;
    assign redirect_in_range = bus.redirect_pc < 32'(DEPTH);

`ifdef IFETCH_JUMP_DECODE_EN
    logic is_jump;
    assign is_jump = (instruction_reg[31:24] == 8'h01) || (instruction_reg[31:24] == 8'h02);
`endif

    // Program loads are only accepted while the sequencer is parked.
    always_ff @(posedge clock) begin
        if (!reset && bus.prog_we && !busy_reg) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            pc_reg           <= '0;
            instruction_reg  <= '0;
            write_enable_reg <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_reg <= S_FETCH;
                        pc_reg    <= '0;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                        error_reg <= 1'b0;
                    end
                end
                S_FETCH: begin
                    instruction_reg <= mem[pc_reg];
                    state_reg       <= S_SETUP;
                end
                S_SETUP: begin
                    write_enable_reg <= 1'b1;
                    state_reg        <= S_COMMIT;
                end
                S_COMMIT: begin
                    write_enable_reg <= 1'b0;
                    instruction_reg  <= '0;
                    state_reg        <= S_FETCH;
                    if (bus.redirect && redirect_in_range) begin
                        pc_reg <= bus.redirect_pc[AW-1:0];
                    end else if (bus.redirect) begin
                        error_reg <= 1'b1;
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`ifdef IFETCH_JUMP_DECODE_EN
                    end else if (is_jump) begin
                        pc_reg <= instruction_reg[AW-1:0];
`endif
                    end else if (instruction_reg == 32'h0000_0000 || pc_reg == LAST_PC) begin
                        // Halt word or end of memory: no wrap back to address 0.
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        pc_reg <= pc_reg + AW'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instruction  = instruction_reg;
    assign bus.write_enable = write_enable_reg;
    assign bus.pc           = pc_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.error        = error_reg;
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: DEPTH, default 64, instruction memory depth in 32-bit words.
REQ-002 Parameter: AW, default 6, program-counter and memory address width; DEPTH SHALL equal 2**AW.
REQ-003 Port: clock, input, 1, single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset, input, 1, synchronous active-high reset.
REQ-005 Port: start, input, 1, single-cycle pulse that begins execution from address 0.
REQ-006 Port: prog_we, input, 1, instruction-memory write strobe.
REQ-007 Port: prog_addr, input, AW, instruction-memory write address.
REQ-008 Port: prog_data, input, 32, instruction-memory write data.
REQ-009 Port: redirect, input, 1, branch/jump taken, driven by the downstream execute core.
REQ-010 Port: redirect_pc, input, 32, word-address target; valid while redirect=1.
REQ-011 Port: instruction, output, 32, instruction presented to the execute core.
REQ-012 Port: write_enable, output, 1, commit strobe to the execute core.
REQ-013 Port: pc, output, AW, word address of the presented instruction.
REQ-014 Port: busy, output, 1, high in every state except IDLE and DONE.
REQ-015 Port: done, output, 1, high in DONE.
REQ-016 Port: error, output, 1, sticky flag for a redirect target outside the memory range.

Function
REQ-017 The FSM SHALL have exactly five states: IDLE, FETCH, SETUP, COMMIT, DONE.
REQ-018 IDLE->FETCH on start=1; DONE->FETCH on start=1, which also clears error; start SHALL be ignored in FETCH, SETUP and COMMIT.
REQ-019 FETCH SHALL perform a synchronous memory read at pc; FETCH->SETUP unconditionally.
REQ-020 SETUP SHALL drive instruction=mem[pc] with write_enable=0; SETUP->COMMIT unconditionally.
REQ-021 COMMIT SHALL hold instruction stable with write_enable=1 for exactly one cycle.
REQ-022 Per-instruction latency SHALL be 3 cycles; the first write_enable SHALL assert on the 3rd edge after the edge that samples start.
REQ-023 Next-PC selection in COMMIT, in priority order:
- if redirect=1 and redirect_pc<DEPTH, next pc=redirect_pc[AW-1:0];
- if redirect=1 and redirect_pc>=DEPTH, set error=1 and go to DONE;
- if instruction==32'h0000_0000 (halt), go to DONE;
- if pc==DEPTH-1, go to DONE (no wrap-around);
- otherwise pc+1.
In every non-DONE case the next state is FETCH.
REQ-024 redirect SHALL be sampled only in COMMIT and ignored in all other states.
REQ-025 prog_we SHALL write mem[prog_addr] only when busy=0; writes while busy=1 SHALL be dropped.
REQ-026 In IDLE and DONE, instruction SHALL be 0, write_enable 0, and pc held.
REQ-027 The instruction memory SHALL NOT be reset.

Reset
REQ-028 reset=1 SHALL force state=IDLE, pc=0, instruction=0, write_enable=0, busy=0, done=0, error=0 on the next edge, from any state.
REQ-029 reset SHALL take priority over start, redirect and prog_we in the same cycle.
REQ-030 Reset during COMMIT SHALL drop write_enable on that edge with no pc update.

Configuration
REQ-031 Macro IFETCH_JUMP_DECODE_EN:
- defined: in COMMIT, an instruction with opcode [31:24]=8'h01 (J) or 8'h02 (JAL) SHALL set next pc=instruction[AW-1:0] locally; redirect SHALL still take priority.
- undefined: J and JAL SHALL follow only the redirect input, like any other instruction.

Verification
REQ-032 Load mem[0..2]=32'h0503_0201, 32'h0606_0504, 0; pulse start -> write_enable high on cycles 3 and 6 with pc=0 then 1; done=1 after the halt word commits.
REQ-033 mem[0]=32'h4101_0203; redirect=1, redirect_pc=5 in the first COMMIT -> next SETUP shows pc=5, instruction=mem[5].
REQ-034 redirect_pc=100 (DEPTH=64) in COMMIT -> error=1, done=1, write_enable stays 0; a new start clears error.
REQ-035 All 64 words nonzero, no redirect -> 64 commits, then DONE at pc=63, with no wrap to 0.
REQ-036 Assert reset in the COMMIT of pc=2 -> next cycle state=IDLE, pc=0, outputs 0; prog_we at pc=1 while busy leaves memory unchanged.
REQ-037 With IFETCH_JUMP_DECODE_EN, mem[0]=32'h0100_000A and no redirect -> next pc=10; without the macro -> next pc=1.
